prod_accumulator: RTL and testbench



---
 rtl/prod_accumulator.sv | 94 +++++++++
 tb/tb_prod_accumulator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/prod_accumulator.sv
// prod_accumulator: sums groups of N_TERMS unsigned 6-bit products and
// presents each group sum with a sticky overflow flag on a valid/ready output.
module prod_accumulator #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             overflow,
    output logic [3:0]       count
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             accept;
    logic             handshake;
    logic             last_term;
    logic [SUM_W-1:0] add_full;

    assign accept    = in_valid && (state == ACCUM);
    assign handshake = out_ready && (state == HOLD);
    assign last_term = (count == 4'(N_TERMS - 1));
    assign add_full  = {1'b0, sum} + SUM_W'(prod);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; clear overrides both accept and handshake
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = ACCUM;
        end else begin
            case (state)
                ACCUM: if (accept && last_term) state_nx = HOLD;
                HOLD:  if (handshake)           state_nx = ACCUM;
                default:                        state_nx = ACCUM;
            endcase
        end
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM:   in_ready  = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b1;
        endcase
    end

    // Accumulator, sticky carry flag and term counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else if (clear) begin
            sum      <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else if (accept) begin
            sum      <= add_full[ACC_W-1:0];
            overflow <= overflow | add_full[ACC_W];
            count    <= count + 4'd1;
        end else if (handshake) begin
            sum      <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end
    end

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench for prod_accumulator: two instances (ACC_W=8 and ACC_W=7)
// share all stimulus; a bench-side model predicts state and a scoreboard queue
// holds completed group results until the output handshake.
module tb_prod_accumulator;

    localparam int N = 4;

    typedef struct {
        logic [7:0] s8;
        logic       o8;
        logic [6:0] s7;
        logic       o7;
    } result_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] prod = '0;
    logic       out_ready = 1'b0;

    logic       in_ready8, out_valid8, overflow8;
    logic [7:0] sum8;
    logic [3:0] count8;
    logic       in_ready7, out_valid7, overflow7;
    logic [6:0] sum7;
    logic [3:0] count7;

    int checks = 0;
    int failures = 0;

    result_t    sb_q[$];
    logic       m_hold;
    int         m_cnt;
    logic [7:0] m_acc8;
    logic       m_ovf8;
    logic [6:0] m_acc7;
    logic       m_ovf7;

    always #5 clk = ~clk;

    prod_accumulator #(.N_TERMS(N), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready8), .prod(prod),
        .out_valid(out_valid8), .out_ready(out_ready),
        .sum(sum8), .overflow(overflow8), .count(count8)
    );

    prod_accumulator #(.N_TERMS(N), .ACC_W(7)) u_dut7 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready7), .prod(prod),
        .out_valid(out_valid7), .out_ready(out_ready),
        .sum(sum7), .overflow(overflow7), .count(count7)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hold = 1'b0;
        m_cnt  = 0;
        m_acc8 = '0;
        m_ovf8 = 1'b0;
        m_acc7 = '0;
        m_ovf7 = 1'b0;
    endtask

    task automatic check_outputs(input string ctx);
        check_eq({ctx, ".in_ready8"},  32'(in_ready8),  32'(!m_hold));
        check_eq({ctx, ".out_valid8"}, 32'(out_valid8), 32'(m_hold));
        check_eq({ctx, ".in_ready7"},  32'(in_ready7),  32'(!m_hold));
        check_eq({ctx, ".out_valid7"}, 32'(out_valid7), 32'(m_hold));
        check_eq({ctx, ".count8"},     32'(count8),     32'(m_cnt));
        check_eq({ctx, ".count7"},     32'(count7),     32'(m_cnt));
        check_eq({ctx, ".sum8"},       32'(sum8),       32'(m_acc8));
        check_eq({ctx, ".ovf8"},       32'(overflow8),  32'(m_ovf8));
        check_eq({ctx, ".sum7"},       32'(sum7),       32'(m_acc7));
        check_eq({ctx, ".ovf7"},       32'(overflow7),  32'(m_ovf7));
    endtask

    // Drive one cycle of inputs, check current outputs, advance the model.
    task automatic step(input logic v, input logic [5:0] p, input logic ordy, input logic clr);
        logic [8:0] t8;
        logic [7:0] t7;
        result_t    r;
        in_valid  = v;
        prod      = p;
        out_ready = ordy;
        clear     = clr;
        #1;
        check_outputs("step");
        if (clr) begin
            if (m_hold && sb_q.size() > 0) void'(sb_q.pop_front());
            model_reset();
        end else if (m_hold) begin
            if (ordy) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_empty_on_handshake", 32'(sb_q.size()), 32'd1);
                end else begin
                    r = sb_q.pop_front();
                    check_eq("hs.sum8", 32'(sum8),      32'(r.s8));
                    check_eq("hs.ovf8", 32'(overflow8), 32'(r.o8));
                    check_eq("hs.sum7", 32'(sum7),      32'(r.s7));
                    check_eq("hs.ovf7", 32'(overflow7), 32'(r.o7));
                end
                model_reset();
            end
        end else if (v) begin
            t8 = {1'b0, m_acc8} + {3'b0, p};
            t7 = {1'b0, m_acc7} + {2'b0, p};
            m_ovf8 = m_ovf8 | t8[8];
            m_acc8 = t8[7:0];
            m_ovf7 = m_ovf7 | t7[7];
            m_acc7 = t7[6:0];
            m_cnt++;
            if (m_cnt == N) begin
                m_hold = 1'b1;
                r.s8 = m_acc8; r.o8 = m_ovf8;
                r.s7 = m_acc7; r.o7 = m_ovf7;
                sb_q.push_back(r);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 6'd0, ordy, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset held from time zero: outputs must already be at defaults
        #1;
        check_outputs("reset0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic group: 49 x4 (ACC_W=8 -> 196; ACC_W=7 wraps to 68 with overflow)
        for (int i = 0; i < 4; i++) step(1'b1, 6'd49, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Next group after the wrapping one: overflow must be clean again
        for (int i = 1; i <= 4; i++) step(1'b1, 6'(i), 1'b1, 1'b0);
        idle(1'b1);

        // Backpressure: 63 x4, then out_ready low with in_valid pulses ignored
        for (int i = 0; i < 4; i++) step(1'b1, 6'd63, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'((i % 2) == 0), 6'd7, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Input gaps: in_valid toggling with prod=9
        for (int i = 0; i < 8; i++) step(1'((i % 2) == 0), 6'd9, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Clear priority over an accept
        step(1'b1, 6'd20, 1'b0, 1'b0);
        step(1'b1, 6'd20, 1'b0, 1'b0);
        step(1'b1, 6'd20, 1'b0, 1'b1);
        idle(1'b0);

        // Clear priority over the output handshake
        for (int i = 0; i < 4; i++) step(1'b1, 6'd5, 1'b0, 1'b0);
        step(1'b0, 6'd0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b0);

        // Asynchronous reset mid-group (count=2), observed before any edge
        step(1'b1, 6'd10, 1'b0, 1'b0);
        step(1'b1, 6'd10, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        sb_q.delete();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // First accept right after reset release, full group delivered
        for (int i = 0; i < 4; i++) step(1'b1, 6'(3 * i + 1), 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
